// File: rtl/softmax_pkg.sv
// Shared constants and types for the softmax datapath blocks, including the
// log2 unit's word format, FSM encoding and zero-input result.
package softmax_pkg;

  localparam int DATA_SIZE = 32;
  localparam int FRAC_BITS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NORM   = 2'd1,
    SQUARE = 2'd2,
    DONE   = 2'd3
  } log_2_state_t;

  // log2(0) is reported as the most negative representable value.
  localparam logic [DATA_SIZE-1:0] ZERO_RESULT = {1'b1, {(DATA_SIZE-1){1'b0}}};

endpackage

// File: rtl/leading_one_detect.sv
// Combinational leading-one detector: index of the most significant set bit
// of a word, plus a flag for the all-zero word (index is 0 in that case).
module leading_one_detect #(
  parameter int width = 32,
  parameter int idx_w = $clog2(width)
) (
  input  logic [width-1:0] word,
  output logic [idx_w-1:0] index,
  output logic             all_zero
);

  // Ascending scan so the highest set bit is the last one to win.
  always_comb begin
    index = '0;
    for (int i = 0; i < width; i++) begin
      if (word[i]) begin
        index = idx_w'(i);
      end
    end
  end

  assign all_zero = (word == '0);

endmodule

// File: rtl/log_2_block.sv
// Fixed-point log2 by normalisation and repeated squaring, one fraction bit
// per cycle. Optional LOG_2_ZERO_ERR_EN adds a zero-input flag output.
//
// Handshake: an input is taken on a rising edge where log_2_data_valid_i and
// log_2_data_ready_o are both high; a result is taken on a rising edge where
// log_2_data_valid_o and log_2_data_ready_i are both high, and data_o/valid_o
// are held unchanged until that edge.
module log_2_block
  import softmax_pkg::*;
#(
  parameter int data_size = DATA_SIZE,
  parameter int frac_bits = FRAC_BITS
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [data_size-1:0] log_2_data_i,
  input  logic                 log_2_data_valid_i,
  output logic                 log_2_data_ready_o,
  output logic [data_size-1:0] log_2_data_o,
  output logic                 log_2_data_valid_o,
  input  logic                 log_2_data_ready_i
`ifdef LOG_2_ZERO_ERR_EN
  ,
  output logic                 log_2_zero_err_o
`endif
);

  localparam int IDX_W  = $clog2(data_size);
  localparam int INT_W  = data_size - frac_bits;
  localparam int CNT_W  = $clog2(frac_bits + 1);
  localparam int PROD_W = 2 * data_size;

  log_2_state_t state, state_nxt;

  logic [data_size-1:0] in_q;
  logic [data_size-1:0] mant_q;
  logic [data_size-1:0] mant_nxt;
  logic [data_size-1:0] data_q;
  logic [INT_W-1:0]     int_q;
  logic [frac_bits-1:0] frac_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 zero_q;
  logic                 valid_q;
  logic [PROD_W-1:0]    prod;
  logic                 sq_bit;
  logic                 sq_last;
  logic [IDX_W-1:0]     lead_idx;
  logic                 lead_zero;
  logic                 unused_prod;

  leading_one_detect #(
    .width (data_size),
    .idx_w (IDX_W)
  ) u_lod (
    .word     (in_q),
    .index    (lead_idx),
    .all_zero (lead_zero)
  );

  // Mantissa is Q1.31, so its square is Q2.62; bit 63 set means m*m >= 2.
  always_comb begin
    prod     = {{data_size{1'b0}}, mant_q} * {{data_size{1'b0}}, mant_q};
    sq_bit   = prod[PROD_W-1];
    mant_nxt = sq_bit ? prod[PROD_W-1:data_size] : prod[PROD_W-2:data_size-1];
  end

  assign unused_prod = ^prod[data_size-2:0];
  assign sq_last     = (cnt_q == CNT_W'(frac_bits - 1));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (log_2_data_valid_i) state_nxt = NORM;
      NORM:    state_nxt = lead_zero ? DONE : SQUARE;
      SQUARE:  if (sq_last) state_nxt = DONE;
      DONE:    if (valid_q && log_2_data_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    log_2_data_ready_o = (state == IDLE);
  end

  // The result register loads on the first DONE cycle, which gives the
  // fixed frac_bits+2 edge latency (2 edges for a zero input).
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      in_q    <= '0;
      mant_q  <= '0;
      int_q   <= '0;
      frac_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (log_2_data_valid_i) begin
            in_q <= log_2_data_i;
          end
        end
        NORM: begin
          zero_q <= lead_zero;
          int_q  <= INT_W'(lead_idx) - INT_W'(frac_bits);
          mant_q <= in_q << (IDX_W'(data_size - 1) - lead_idx);
          frac_q <= '0;
          cnt_q  <= '0;
        end
        SQUARE: begin
          mant_q <= mant_nxt;
          frac_q <= {frac_q[frac_bits-2:0], sq_bit};
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        DONE: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
            data_q  <= zero_q ? ZERO_RESULT : {int_q, frac_q};
          end else if (log_2_data_ready_i) begin
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign log_2_data_o       = data_q;
  assign log_2_data_valid_o = valid_q;

`ifdef LOG_2_ZERO_ERR_EN
  logic res_zero_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      res_zero_q <= 1'b0;
    end else if (state == DONE && !valid_q) begin
      res_zero_q <= zero_q;
    end
  end

  assign log_2_zero_err_o = valid_q & res_zero_q;
`endif

endmodule

// File: tb/tb_log_2_block.sv
// Self-checking bench for log_2_block: directed corner values, stall, busy
// and mid-operation reset cases, then randomized inputs with random back-pressure.
module tb_log_2_block;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] data_i  = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
`ifdef LOG_2_ZERO_ERR_EN
  logic        zero_err_o;
`endif

  log_2_block dut (
    .clock_i            (clock_i),
    .reset_i            (reset_i),
    .log_2_data_i       (data_i),
    .log_2_data_valid_i (valid_i),
    .log_2_data_ready_o (ready_o),
    .log_2_data_o       (data_o),
    .log_2_data_valid_o (valid_o),
    .log_2_data_ready_i (ready_i)
`ifdef LOG_2_ZERO_ERR_EN
    ,
    .log_2_zero_err_o   (zero_err_o)
`endif
  );

  // clock / cycle counter
  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  // scoreboard state
  logic [31:0] exp_q[$];
  int          tol_q[$];
  int          lat_q[$];
  int          acc_q[$];
  bit          zin_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int          last_acc = 0;
  bit          rnd_rdy = 1'b0;

  task automatic check(string name, bit ok, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: log2(x) = p + log2(x / 2^p) with x/2^p in [1,2); the fraction
  // bits come from repeatedly squaring that value, halving whenever it reaches 2.
  function automatic logic [31:0] ref_log2(logic [31:0] x);
    int              p;
    longint unsigned m;
    longint unsigned sq;
    logic [15:0]     f;
    logic [15:0]     ip;
    if (x == 32'd0) return 32'h8000_0000;
    p = 31;
    while (x[p] == 1'b0) p--;
    ip = 16'(p - 16);
    m  = 64'(x) << (31 - p);
    f  = '0;
    for (int k = 0; k < 16; k++) begin
      sq = m * m;
      if (sq >= 64'h8000_0000_0000_0000) begin
        f = {f[14:0], 1'b1};
        m = sq >> 32;
      end else begin
        f = {f[14:0], 1'b0};
        m = (sq >> 31) & 64'h0000_0000_FFFF_FFFF;
      end
    end
    return {ip, f};
  endfunction

  // driver tasks
  task automatic send(logic [31:0] d, logic [31:0] exp, int tol, int lat, bit z);
    int n = 0;
    @(posedge clock_i); #1;
    valid_i = 1'b1;
    data_i  = d;
    @(negedge clock_i);
    while (!ready_o && n < 300) begin
      @(negedge clock_i);
      n++;
    end
    if (!ready_o) begin
      check("accept_timeout", 1'b0, 32'(ready_o), 32'd1);
      valid_i = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    tol_q.push_back(tol);
    lat_q.push_back(lat);
    zin_q.push_back(z);
    acc_q.push_back(cyc + 1);
    last_acc = cyc + 1;
    @(posedge clock_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic send_model(logic [31:0] d);
    send(d, ref_log2(d), 0, (d == 32'd0) ? 2 : 18, d == 32'd0);
  endtask

  task automatic wait_valid(int budget);
    int n = 0;
    while (!valid_o && n < budget) begin
      @(negedge clock_i);
      n++;
    end
    if (!valid_o) check("valid_timeout", 1'b0, 32'(valid_o), 32'd1);
  endtask

  always @(posedge clock_i) begin
    if (rnd_rdy) begin
      #1 ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // monitor: compares every presented result against the queue head
  logic        prev_v   = 1'b0;
  logic [31:0] last_res = '0;
  logic [31:0] mdiff;
  int          sd;

  always @(negedge clock_i) begin
    if (reset_i) begin
      prev_v   = 1'b0;
      last_res = '0;
    end else begin
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1'b0, data_o, 32'd0);
        end else begin
          if (!prev_v) check("latency", (cyc - acc_q[0]) == lat_q[0], 32'(cyc - acc_q[0]), 32'(lat_q[0]));
          else         check("hold_stable", data_o == last_res, data_o, last_res);
          mdiff = data_o - exp_q[0];
          sd    = $signed(mdiff);
          check("result", (sd <= tol_q[0]) && (sd >= -tol_q[0]), data_o, exp_q[0]);
`ifdef LOG_2_ZERO_ERR_EN
          check("zero_err", zero_err_o == zin_q[0], 32'(zero_err_o), 32'(zin_q[0]));
`endif
          if (ready_i) begin
            void'(exp_q.pop_front());
            void'(tol_q.pop_front());
            void'(lat_q.pop_front());
            void'(zin_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
        last_res = data_o;
      end else begin
        check("data_held", data_o == last_res, data_o, last_res);
`ifdef LOG_2_ZERO_ERR_EN
        check("zero_err_idle", zero_err_o == 1'b0, 32'(zero_err_o), 32'd0);
`endif
      end
      prev_v = valid_o;
    end
  end

  // main sequence
  initial begin
    int n;
    logic [31:0] x;

    repeat (3) @(posedge clock_i);
    #1 reset_i = 1'b0;
    @(negedge clock_i);
    check("reset_ready", ready_o == 1'b1, 32'(ready_o), 32'd1);
    check("reset_valid", valid_o == 1'b0, 32'(valid_o), 32'd0);
    check("reset_data", data_o == 32'd0, data_o, 32'd0);

    send(32'h0001_0000, 32'h0000_0000, 0, 18, 1'b0);
    send(32'h0002_0000, 32'h0001_0000, 0, 18, 1'b0);
    send(32'h0000_8000, 32'hFFFF_0000, 0, 18, 1'b0);
    send(32'h0001_8000, 32'h0000_95C0, 1, 18, 1'b0);
    send(32'hFFFF_FFFF, 32'h000F_FFFF, 1, 18, 1'b0);
    send(32'h0000_0001, 32'hFFF0_0000, 0, 18, 1'b0);
    send(32'h0000_0000, 32'h8000_0000, 0, 2,  1'b1);

    // back-pressure: result must sit unchanged while ready_i is low
    wait_valid(60);
    @(posedge clock_i); #1 ready_i = 1'b0;
    send(32'h0002_0000, 32'h0001_0000, 0, 18, 1'b0);
    wait_valid(60);
    repeat (5) begin
      @(negedge clock_i);
      check("stall_valid", valid_o == 1'b1, 32'(valid_o), 32'd1);
    end
    @(posedge clock_i); #1 ready_i = 1'b1;

    // a valid pulse while busy must be ignored
    send(32'h0000_8000, 32'hFFFF_0000, 0, 18, 1'b0);
    repeat (4) @(posedge clock_i);
    #1;
    valid_i = 1'b1;
    data_i  = 32'h1234_5678;
    @(negedge clock_i);
    check("busy_ready_low", ready_o == 1'b0, 32'(ready_o), 32'd0);
    @(posedge clock_i); #1 valid_i = 1'b0;

    // reset during the seventh squaring cycle abandons the operation
    wait_valid(60);
    send(32'h0001_8000, 32'h0000_95C0, 1, 18, 1'b0);
    repeat (7) @(posedge clock_i);
    #1 reset_i = 1'b1;
    @(posedge clock_i); #1 reset_i = 1'b0;
    exp_q.delete();
    tol_q.delete();
    lat_q.delete();
    zin_q.delete();
    acc_q.delete();
    @(negedge clock_i);
    check("midreset_ready", ready_o == 1'b1, 32'(ready_o), 32'd1);
    check("midreset_valid", valid_o == 1'b0, 32'(valid_o), 32'd0);
    repeat (25) @(negedge clock_i);
    send(32'h0004_0000, 32'h0002_0000, 0, 18, 1'b0);

    // randomized inputs over the full dynamic range with random stalls
    wait_valid(60);
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) x = 32'd0;
      send_model(x);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clock_i);
      n++;
    end
    rnd_rdy = 1'b0;
    if (exp_q.size() != 0) check("drain_timeout", 1'b0, 32'(exp_q.size()), 32'd0);
    @(posedge clock_i); #1 ready_i = 1'b1;
    repeat (3) @(negedge clock_i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/log_2_block.md
LOG_2_BLOCK -- requirements
Module: log_2_block

Interface
REQ-001 SHALL have parameter: data_size, 32, width of input and output words.
REQ-002 SHALL have parameter: frac_bits, 16, fraction bits of both input and output formats.
REQ-003 SHALL have port: clock_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: log_2_data_i  input  data_size  unsigned fixed point, 16 integer, 16 fraction (sum of exp terms).
REQ-006 SHALL have port: log_2_data_valid_i  input  1  input word valid.
REQ-007 SHALL have port: log_2_data_ready_o  output  1  block can accept an input.
REQ-008 SHALL have port: log_2_data_o  output  data_size  log2 of input, 1 sign, 15 integer, 16 fraction, two's complement.
REQ-009 SHALL have port: log_2_data_valid_o  output  1  result valid, held until accepted.
REQ-010 SHALL have port: log_2_data_ready_i  input  1  downstream accepts result.

Function
REQ-011 SHALL implement FSM states IDLE, NORM, SQUARE, DONE.
REQ-012 SHALL assert ready_o only in IDLE; accept occurs on the edge where valid_i and ready_o are both high; input is captured.
REQ-013 SHALL, in NORM (one cycle), find leading-one index p of captured input, set integer part to p - frac_bits (range -16..15), left-shift input so its MSB is set (mantissa Q1.31).
REQ-014 SHALL, in SQUARE, produce one fraction bit per cycle, MSB first, for exactly frac_bits cycles: 64-bit product m*m; if product bit 63 set -> bit=1, m=product[63:32]; else bit=0, m=product[62:31]; truncation only.
REQ-015 SHALL enter DONE after the last SQUARE cycle, drive data_o = {sign-extended integer part, fraction bits} and valid_o high.
REQ-016 SHALL hold data_o and valid_o stable in DONE while ready_i is low; on valid_o & ready_i return to IDLE, valid_o low next cycle.
REQ-017 SHALL have fixed latency: valid_o high on the (frac_bits + 2)-th rising edge after the accepting edge (18 by default).
REQ-018 SHALL, for zero input, skip SQUARE, go NORM -> DONE, output 0x8000_0000 (most negative value).
REQ-019 SHALL ignore valid_i outside IDLE; no input buffering.
REQ-020 SHALL keep data_o at its last result value outside DONE; only valid_o qualifies it.

Reset
REQ-021 SHALL, on reset_i high at a rising edge, set state IDLE, valid_o 0, data_o 0, internal mantissa/counters 0; ready_o 1 in the first cycle after reset.
REQ-022 SHALL abandon any in-flight computation on reset mid-operation; no result is later emitted for it.

Configuration
REQ-023 SHALL support macro LOG_2_ZERO_ERR_EN: when defined, adds port log_2_zero_err_o output 1, high with valid_o when the result came from a zero input, else 0, reset 0.
REQ-024 SHALL, without LOG_2_ZERO_ERR_EN, omit that port; zero-input behaviour per REQ-018 unchanged.

Structure
REQ-025 SHALL take DATA_SIZE, FRAC_BITS, state encoding and the zero-input result constant from shared package softmax_pkg.
REQ-026 SHALL place leading-one detection in combinational sub-module leading_one_detect (input word -> index p and all-zero flag).

Verification
REQ-027 SHALL cover: input 0x0001_0000 (1.0) -> 0x0000_0000 after 18 edges; input 0x0002_0000 -> 0x0001_0000.
REQ-028 SHALL cover: input 0x0000_8000 (0.5) -> 0xFFFF_0000; input 0x0001_8000 (1.5) -> 0x0000_95C0 within 1 LSB.
REQ-029 SHALL cover: input 0xFFFF_FFFF -> 0x000F_FFFF within 1 LSB; input 0x0000_0001 -> 0xFFF0_0000.
REQ-030 SHALL cover: input 0 -> 0x8000_0000 after 2 edges, zero_err_o 1 when LOG_2_ZERO_ERR_EN defined.
REQ-031 SHALL cover: ready_i held low 5 cycles in DONE -> data_o/valid_o stable; valid_i pulsed during SQUARE -> ignored.
REQ-032 SHALL cover: reset_i pulsed at SQUARE cycle 7 -> valid_o stays 0, ready_o 1 next cycle, next input 0x0004_0000 -> 0x0002_0000.
